// File: rtl/cr_prefix_attach_mem_arb_if.sv
// Handshake bundle between the prefix-memory arbiter, its two requesters and the SRAM macro.
// Latency: none (wires only). Backpressure: dp/rb requests are held until dp_gnt / rb_ack.
// slave = arbiter side, master = requesters plus memory model.
interface cr_prefix_attach_mem_arb_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 64
);
    logic              dp_req;
    logic [ADDR_W-1:0] dp_addr;
    logic              dp_gnt;
    logic              dp_yield;
    logic              dp_rvld;
    logic [DATA_W-1:0] dp_rdata;

    logic              rb_req;
    logic              rb_wr;
    logic [ADDR_W-1:0] rb_addr;
    logic [DATA_W-1:0] rb_wdata;
    logic              rb_ack;
    logic [DATA_W-1:0] rb_rdata;

    logic              mem_cs;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  dp_req, dp_addr, rb_req, rb_wr, rb_addr, rb_wdata, mem_rdata,
        output dp_gnt, dp_yield, dp_rvld, dp_rdata, rb_ack, rb_rdata,
               mem_cs, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output dp_req, dp_addr, rb_req, rb_wr, rb_addr, rb_wdata, mem_rdata,
        input  dp_gnt, dp_yield, dp_rvld, dp_rdata, rb_ack, rb_rdata,
               mem_cs, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cr_prefix_attach_mem_arb.sv
// Arbitrates a single-port prefix memory between the datapath read port and the register port.
// Latency: grant/memory drive combinational; dp_rvld and rb_ack one cycle after grant.
// Backpressure: dp has priority; rb is forced through after STARVE_MAX consecutive losses.
module cr_prefix_attach_mem_arb #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    cr_prefix_attach_mem_arb_if.slave bus,
    output logic                      starve_hit
);
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_RB_ACK = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_nxt;
    logic [7:0]        starve_cnt_q;
    logic [7:0]        starve_cnt_nxt;
    logic              rb_elig;
    logic              rb_win;
    logic              dp_gnt;
    logic              dp_rvld_q;
    logic              rb_rd_q;
    logic              mem_cs;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    // rb_req is ignored while its previous access is being acknowledged
    always_comb begin
        state_nxt = state_q;
        rb_elig   = bus.rb_req & (state_q == ST_IDLE);
        rb_win    = rb_elig & (~bus.dp_req | (starve_cnt_q == STARVE_LIM));
        dp_gnt    = bus.dp_req & ~rb_win;
        case (state_q)
            ST_IDLE:   if (rb_win) state_nxt = ST_RB_ACK;
            ST_RB_ACK: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        starve_cnt_nxt = starve_cnt_q;
        if (rb_win || !bus.rb_req) begin
            starve_cnt_nxt = 8'd0;
        end else if (rb_elig && (starve_cnt_q != STARVE_LIM)) begin
            starve_cnt_nxt = starve_cnt_q + 8'd1;
        end
    end

    always_comb begin
        mem_cs    = dp_gnt | rb_win;
        mem_we    = rb_win & bus.rb_wr;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rb_win) begin
            mem_addr = bus.rb_addr;
        end else if (dp_gnt) begin
            mem_addr = bus.dp_addr;
        end
        if (mem_we) begin
            mem_wdata = bus.rb_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            starve_cnt_q <= 8'd0;
            dp_rvld_q    <= 1'b0;
            rb_rd_q      <= 1'b0;
            starve_hit   <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            starve_cnt_q <= starve_cnt_nxt;
            dp_rvld_q    <= dp_gnt;
            if (rb_win) begin
                rb_rd_q <= ~bus.rb_wr;
            end
            // only a grant that pre-empted a live dp request counts as starvation relief
            if (rb_win && bus.dp_req) begin
                starve_hit <= 1'b1;
            end
        end
    end

    assign bus.dp_gnt    = dp_gnt;
    assign bus.dp_yield  = bus.dp_req & rb_win;
    assign bus.dp_rvld   = dp_rvld_q;
    assign bus.dp_rdata  = dp_rvld_q ? bus.mem_rdata : '0;
    assign bus.rb_ack    = (state_q == ST_RB_ACK);
    assign bus.rb_rdata  = ((state_q == ST_RB_ACK) && rb_rd_q) ? bus.mem_rdata : '0;
    assign bus.mem_cs    = mem_cs;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
endmodule

// File: tb/tb_cr_prefix_attach_mem_arb.sv
// Bench for cr_prefix_attach_mem_arb: table vectors, directed sequences and random traffic
// checked against a transaction-level model of the arbitration rules.
module tb_cr_prefix_attach_mem_arb;
    localparam int STARVE_MAX = 8;

    logic clk;
    logic rst_n;
    logic starve_hit;

    cr_prefix_attach_mem_arb_if #(.ADDR_W(6), .DATA_W(64)) bus ();

    cr_prefix_attach_mem_arb #(.ADDR_W(6), .DATA_W(64), .STARVE_MAX(STARVE_MAX)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave),
        .starve_hit (starve_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // single-port SRAM: one-cycle read latency, junk on the read bus when not reading
    logic [63:0] env_mem [64];
    always @(posedge clk) begin
        if (bus.mem_cs && bus.mem_we) env_mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_cs && !bus.mem_we) bus.mem_rdata <= env_mem[bus.mem_addr];
        else bus.mem_rdata <= {$urandom, $urandom};
    end

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [63:0] ref_mem [64];
    bit          m_busy;
    int          m_losses;
    bit          m_rvld;
    logic [63:0] m_rdata;
    bit          m_ack;
    logic [63:0] m_rbdata;
    bit          m_hit;
    bit          e_win;
    bit          e_gnt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_losses = 0; m_rvld = 0; m_rdata = '0;
        m_ack = 0; m_rbdata = '0; m_hit = 0; e_win = 0; e_gnt = 0;
    endtask

    // one clock cycle: drive, compare every output against the model, advance the model
    task automatic step(input bit dq, input logic [5:0] da, input bit rq, input bit rw,
                        input logic [5:0] ra, input logic [63:0] wd);
        @(negedge clk);
        bus.dp_req = dq; bus.dp_addr = da;
        bus.rb_req = rq; bus.rb_wr = rw; bus.rb_addr = ra; bus.rb_wdata = wd;
        #1;
        chk("dp_rvld", bus.dp_rvld, m_rvld);
        chk("dp_rdata", bus.dp_rdata, m_rvld ? m_rdata : 64'd0);
        chk("rb_ack", bus.rb_ack, m_ack);
        chk("rb_rdata", bus.rb_rdata, m_ack ? m_rbdata : 64'd0);
        chk("starve_hit", starve_hit, m_hit);
        e_win = rq && !m_busy && (!dq || m_losses >= STARVE_MAX);
        e_gnt = dq && !e_win;
        chk("dp_gnt", bus.dp_gnt, e_gnt);
        chk("dp_yield", bus.dp_yield, dq && e_win);
        chk("mem_cs", bus.mem_cs, e_gnt || e_win);
        chk("mem_we", bus.mem_we, e_win && rw);
        chk("mem_addr", bus.mem_addr, e_win ? ra : (e_gnt ? da : 6'd0));
        if (bus.mem_we) chk("mem_wdata", bus.mem_wdata, wd);
        m_rvld = e_gnt;
        if (e_gnt) m_rdata = ref_mem[da];
        m_ack    = e_win;
        m_rbdata = (e_win && !rw) ? ref_mem[ra] : 64'd0;
        if (e_win && rw) ref_mem[ra] = wd;
        if (e_win && dq) m_hit = 1;
        if (e_win || !rq) m_losses = 0;
        else if (!m_busy) m_losses++;
        m_busy = e_win;
    endtask

    task automatic idle();
        step(0, 6'd0, 0, 0, 6'd0, 64'd0);
    endtask

    typedef struct {
        bit          dq;
        logic [5:0]  da;
        bit          rq;
        bit          rw;
        logic [5:0]  ra;
        logic [63:0] wd;
        bit          x_gnt;
        bit          x_yield;
        bit          x_cs;
        bit          x_we;
    } vec_t;

    vec_t tbl [9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          dp_act, rb_wr_r;
        logic [5:0]  dp_a, rb_a, a3;
        logic [63:0] rb_d;
        int          rb_phase;

        tbl[0] = '{1, 6'd1, 1, 0, 6'd2, 64'd0, 1, 0, 1, 0};
        tbl[1] = '{1, 6'd2, 1, 0, 6'd2, 64'd0, 1, 0, 1, 0};
        tbl[2] = '{1, 6'd3, 1, 0, 6'd2, 64'd0, 1, 0, 1, 0};
        tbl[3] = '{0, 6'd0, 1, 0, 6'd2, 64'd0, 0, 0, 1, 0};
        tbl[4] = '{1, 6'd4, 1, 0, 6'd2, 64'd0, 1, 0, 1, 0};
        tbl[5] = '{0, 6'd0, 0, 0, 6'd0, 64'd0, 0, 0, 0, 0};
        tbl[6] = '{0, 6'd0, 1, 1, 6'd7, 64'hCAFE_F00D_1234_5678, 0, 0, 1, 1};
        tbl[7] = '{1, 6'd7, 1, 1, 6'd7, 64'hCAFE_F00D_1234_5678, 1, 0, 1, 0};
        tbl[8] = '{0, 6'd0, 0, 0, 6'd0, 64'd0, 0, 0, 0, 0};

        rst_n = 0;
        bus.dp_req = 0; bus.dp_addr = '0; bus.rb_req = 0; bus.rb_wr = 0;
        bus.rb_addr = '0; bus.rb_wdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_dp_gnt", bus.dp_gnt, 0);
        chk("rst_dp_rvld", bus.dp_rvld, 0);
        chk("rst_rb_ack", bus.rb_ack, 0);
        chk("rst_mem_cs", bus.mem_cs, 0);
        chk("rst_dp_rdata", bus.dp_rdata, 0);
        chk("rst_starve_hit", starve_hit, 0);
        @(negedge clk);
        rst_n = 1;

        // preload every word through the register port
        for (int a = 0; a < 64; a++) begin
            step(0, 6'd0, 1, 1, 6'(a), {$urandom, $urandom});
            idle();
        end

        // dp read sweep, one per cycle
        for (int a = 0; a < 64; a++) step(1, 6'(a), 0, 0, 6'd0, 64'd0);
        idle();

        for (int i = 0; i < 9; i++) begin
            step(tbl[i].dq, tbl[i].da, tbl[i].rq, tbl[i].rw, tbl[i].ra, tbl[i].wd);
            chk("tbl_gnt", bus.dp_gnt, tbl[i].x_gnt);
            chk("tbl_yield", bus.dp_yield, tbl[i].x_yield);
            chk("tbl_cs", bus.mem_cs, tbl[i].x_cs);
            chk("tbl_we", bus.mem_we, tbl[i].x_we);
        end
        chk("wr_then_dp_rd", bus.dp_rdata, 64'hCAFE_F00D_1234_5678);

        // register write then read of addr 5
        step(0, 6'd0, 1, 1, 6'd5, 64'hDEAD_BEEF_0123_4567);
        chk("rb_wr_we", bus.mem_we, 1);
        idle();
        chk("rb_wr_ack", bus.rb_ack, 1);
        chk("rb_wr_rdata0", bus.rb_rdata, 0);
        step(0, 6'd0, 1, 0, 6'd5, 64'd0);
        chk("rb_rd_we", bus.mem_we, 0);
        idle();
        chk("rb_rd_ack", bus.rb_ack, 1);
        chk("rb_rd_data", bus.rb_rdata, 64'hDEAD_BEEF_0123_4567);

        // simultaneous rise, dp leaves after three grants
        for (int c = 0; c < 5; c++) begin
            step(c < 3, 6'(c + 10), 1, 0, 6'd12, 64'd0);
            chk("sim_dp_gnt", bus.dp_gnt, c < 3);
            chk("sim_rb_win", bus.mem_cs & ~bus.dp_gnt, c == 3);
        end
        idle();
        chk("sim_no_hit", starve_hit, 0);

        // starvation: dp held continuously, rb raised at cycle 10
        a3 = 6'd20;
        for (int c = 0; c < 23; c++) begin
            step(1, a3, (c >= 10) && (c <= 19), 0, 6'd30, 64'd0);
            chk("starve_yield", bus.dp_yield, c == 18);
            if (c >= 19) chk("starve_hit_set", starve_hit, 1);
            if (e_gnt) a3 = a3 + 6'd1;
        end
        idle();

        // reset right after an rb read grant
        step(0, 6'd0, 1, 0, 6'd3, 64'd0);
        @(posedge clk); #2;
        rst_n = 0;
        bus.rb_req = 0;
        #1;
        chk("mid_rst_rb_ack", bus.rb_ack, 0);
        chk("mid_rst_rb_rdata", bus.rb_rdata, 0);
        chk("mid_rst_dp_rvld", bus.dp_rvld, 0);
        chk("mid_rst_mem_cs", bus.mem_cs, 0);
        chk("mid_rst_hit", starve_hit, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
        idle();
        idle();
        step(0, 6'd0, 1, 0, 6'd3, 64'd0);
        idle();
        chk("post_rst_ack", bus.rb_ack, 1);
        chk("post_rst_rdata", bus.rb_rdata, ref_mem[3]);

        // random legal traffic
        dp_act = 0; dp_a = '0; rb_phase = 0; rb_wr_r = 0; rb_a = '0; rb_d = '0;
        for (int n = 0; n < 3000; n++) begin
            bit rq;
            if (!dp_act && $urandom_range(0, 99) < 80) begin
                dp_act = 1;
                dp_a   = 6'($urandom_range(0, 15));
            end
            if (rb_phase == 0 && $urandom_range(0, 99) < 30) begin
                rb_phase = 1;
                rb_wr_r  = 1'($urandom_range(0, 1));
                rb_a     = 6'($urandom_range(0, 15));
                rb_d     = {$urandom, $urandom};
            end
            rq = (rb_phase == 1) || (rb_phase == 2 && $urandom_range(0, 1) == 1);
            step(dp_act, dp_a, rq, rb_wr_r, rb_a, rb_d);
            if (e_gnt) dp_act = 0;
            if (rb_phase == 2) rb_phase = 0;
            else if (rb_phase == 1 && e_win) rb_phase = 2;
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
